md_issue_ctrl: RTL and testbench

- Issue and stall controller for the E-stage HI/LO multiply/divide unit.
- Decides when a mult/multu/div/divu in E may start and gates mthi/mtlo writes.
- Models the unit's multi-cycle latency and stalls the D stage while a HI/LO instruction must wait.
- Honours exception requests (req) so that flushed instructions never start or write HI/LO.

---
 rtl/md_issue_ctrl_if.sv | 21 ++
 rtl/md_issue_ctrl.sv | 45 ++++
 tb/tb_md_issue_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: E/D-stage HI/LO issue and stall signals between pipeline and controller
interface md_issue_ctrl_if;
  logic       e_valid;
  logic [3:0] e_op;
  logic       d_uses_hilo;
  logic       req;
  logic       div_zero;
  logic       md_start;
  logic       hilo_we;
  logic       busy;
  logic       stall_d;
  logic       md_done;
  modport master (
    output e_valid, e_op, d_uses_hilo, req, div_zero,
    input  md_start, hilo_we, busy, stall_d, md_done
  );
  modport slave (
    input  e_valid, e_op, d_uses_hilo, req, div_zero,
    output md_start, hilo_we, busy, stall_d, md_done
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: HI/LO mult/div issue and D-stage stall control; MD_DIV0_FAST_EN makes divide-by-zero finish after one RUN cycle
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input logic          clk,
  input logic          reset,
  md_issue_ctrl_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, lat;
  logic             is_md, is_mt, go, md_start, busy, last;
  // State and latency counter; reset abandons any running operation
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // Issue decision (gated by reset so outputs stay low during reset), latency select and countdown
  always_comb begin
    is_md    = bus.e_op inside {4'd1, 4'd2, 4'd3, 4'd4};
    is_mt    = bus.e_op inside {4'd7, 4'd8};
    go       = reset & bus.e_valid & ~bus.req & (state == IDLE);
    md_start = go & is_md;
`ifdef MD_DIV0_FAST_EN
    lat      = (bus.e_op > 4'd2) ? (bus.div_zero ? CNT_W'(1) : CNT_W'(DIV_LAT)) : CNT_W'(MULT_LAT);
`else
    lat      = (bus.e_op > 4'd2) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
`endif
    last     = (state == RUN) && (cnt == CNT_W'(1));
    busy     = (state == RUN) | md_start;
    state_n  = md_start ? RUN : last ? IDLE : state;
    cnt_n    = md_start ? lat : (state == RUN) ? cnt - CNT_W'(1) : cnt;
  end
  assign bus.md_start = md_start;
  assign bus.hilo_we  = go & is_mt;
  assign bus.busy     = busy;
  assign bus.stall_d  = bus.d_uses_hilo & busy;
  assign bus.md_done  = last;
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: randomized and directed checks of md_issue_ctrl against an end-time reference model
module tb_md_issue_ctrl;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  logic clk = 0;
  logic reset = 0;
  int   ncmp = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   run_until = -1;
  logic [4:0] exp_v;
  md_issue_ctrl_if bus();
  md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [4:0] obs();
    return {bus.md_start, bus.hilo_we, bus.busy, bus.stall_d, bus.md_done};
  endfunction
  // Drive one cycle of inputs at the falling edge and predict outputs:
  // the unit is occupied through absolute cycle run_until, which a start sets to now + latency.
  task automatic drive(input logic r, input logic v, input logic [3:0] op,
                       input logic dh, input logic rq, input logic dz);
    logic idle, st, we, bsy, dn;
    int   lat;
    @(negedge clk);
    reset = r; bus.e_valid = v; bus.e_op = op; bus.d_uses_hilo = dh; bus.req = rq; bus.div_zero = dz;
    #1;
    cyc++;
    if (!r) begin
      run_until = cyc;
      exp_v = 5'b0;
    end else begin
      idle = cyc > run_until;
      st   = v && op >= 1 && op <= 4 && !rq && idle;
      we   = v && (op == 7 || op == 8) && !rq && idle;
      lat  = (op >= 3) ? DIV_LAT : MULT_LAT;
`ifdef MD_DIV0_FAST_EN
      if (op >= 3 && dz) lat = 1;
`endif
      bsy  = !idle || st;
      dn   = !idle && cyc == run_until;
      if (st) run_until = cyc + lat;
      exp_v = {st, we, bsy, dh && bsy, dn};
    end
  endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      ncmp++;
      if (obs() !== exp_v) begin nerr++; $display("FAIL idle_drain cyc=%0d got=%b exp=%b", cyc, obs(), exp_v); end
    end
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, 0, 0);
      ncmp++;
      if (obs() !== 5'b0) begin nerr++; $display("FAIL reset_outputs i=%0d got=%b exp=00000", i, obs()); end
    end
    drive(1, 1, 1, 1, 0, 0);
    ncmp++;
    if (bus.md_start !== 1'b1) begin nerr++; $display("FAIL reset_release_start got=%b exp=1", bus.md_start); end
    idle_cycles(MULT_LAT + 1);
  endtask
  task automatic test_mult_latency();
    for (int k = 0; k <= MULT_LAT + 1; k++) begin
      if (k == 0) drive(1, 1, 1, 1, 0, 0); else drive(1, 0, 0, 1, 0, 0);
      ncmp++;
      if (obs() !== exp_v) begin nerr++; $display("FAIL mult_model k=%0d got=%b exp=%b", k, obs(), exp_v); end
      ncmp++;
      if ({bus.busy, bus.stall_d, bus.md_done} !== {k <= MULT_LAT, k <= MULT_LAT, k == MULT_LAT}) begin
        nerr++; $display("FAIL mult_window k=%0d busy/stall/done got=%b", k, {bus.busy, bus.stall_d, bus.md_done});
      end
    end
  endtask
  task automatic test_div_flush();
    drive(1, 1, 3, 0, 1, 0);
    ncmp++;
    if ({bus.md_start, bus.busy} !== 2'b00) begin nerr++; $display("FAIL div_flushed got=%b exp=00", {bus.md_start, bus.busy}); end
    drive(1, 0, 0, 0, 0, 0);
    ncmp++;
    if (bus.busy !== 1'b0) begin nerr++; $display("FAIL div_flush_idle got=%b exp=0", bus.busy); end
    for (int k = 0; k <= DIV_LAT + 1; k++) begin
      if (k == 0) drive(1, 1, 3, 0, 0, 0); else drive(1, 0, 0, 0, 0, 0);
      ncmp++;
      if ({bus.busy, bus.md_done} !== {k <= DIV_LAT, k == DIV_LAT} || obs() !== exp_v) begin
        nerr++; $display("FAIL div_window k=%0d got=%b exp=%b", k, obs(), exp_v);
      end
    end
  endtask
  task automatic test_mthi();
    drive(1, 1, 7, 0, 0, 0);
    ncmp++;
    if (bus.hilo_we !== 1'b1) begin nerr++; $display("FAIL mthi_we got=%b exp=1", bus.hilo_we); end
    drive(1, 1, 8, 0, 1, 0);
    ncmp++;
    if (bus.hilo_we !== 1'b0) begin nerr++; $display("FAIL mtlo_flushed got=%b exp=0", bus.hilo_we); end
    drive(1, 1, 2, 0, 0, 0);
    drive(1, 1, 7, 0, 0, 0);
    ncmp++;
    if ({bus.hilo_we, bus.busy} !== 2'b01) begin nerr++; $display("FAIL mthi_in_run got=%b exp=01", {bus.hilo_we, bus.busy}); end
    drive(1, 1, 3, 0, 0, 0);
    ncmp++;
    if (obs() !== exp_v || bus.md_start !== 1'b0) begin nerr++; $display("FAIL illegal_md_in_run got=%b exp=%b", obs(), exp_v); end
    for (int k = 3; k <= MULT_LAT + 1; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      ncmp++;
      if (bus.md_done !== (k == MULT_LAT)) begin nerr++; $display("FAIL mthi_drain_done k=%0d got=%b", k, bus.md_done); end
    end
  endtask
  task automatic test_mid_events();
    for (int k = 0; k <= DIV_LAT + 1; k++) begin
      if (k == 0) drive(1, 1, 4, 0, 0, 0); else drive(1, 0, 0, 0, k == 3, 0);
      ncmp++;
      if (bus.md_done !== (k == DIV_LAT) || bus.busy !== (k <= DIV_LAT)) begin
        nerr++; $display("FAIL req_in_run k=%0d busy/done got=%b%b", k, bus.busy, bus.md_done);
      end
    end
    for (int k = 0; k <= 4; k++) begin
      if (k == 0) drive(1, 1, 4, 0, 0, 0); else drive(k < 4, 0, 0, 1, 0, 0);
    end
    ncmp++;
    if (obs() !== 5'b0) begin nerr++; $display("FAIL reset_mid_op got=%b exp=00000", obs()); end
    for (int k = 5; k <= DIV_LAT + 2; k++) begin
      drive(1, 0, 0, 1, 0, 0);
      ncmp++;
      if ({bus.busy, bus.md_done} !== 2'b00) begin nerr++; $display("FAIL abandoned_op k=%0d got=%b%b exp=00", k, bus.busy, bus.md_done); end
    end
  endtask
  task automatic test_div0();
    int done_at;
`ifdef MD_DIV0_FAST_EN
    done_at = 1;
`else
    done_at = DIV_LAT;
`endif
    for (int k = 0; k <= done_at + 1; k++) begin
      if (k == 0) drive(1, 1, 3, 0, 0, 1); else drive(1, 0, 0, 0, 0, 1);
      ncmp++;
      if (bus.md_done !== (k == done_at) || bus.busy !== (k <= done_at)) begin
        nerr++; $display("FAIL div0 k=%0d busy/done got=%b%b done_at=%0d", k, bus.busy, bus.md_done, done_at);
      end
    end
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k <= MULT_LAT + 1; k++) begin
      if (k == 0 || k == MULT_LAT + 1) drive(1, 1, 1, 1, 0, 0); else drive(1, 0, 0, 1, 0, 0);
      ncmp++;
      if (obs() !== exp_v) begin nerr++; $display("FAIL b2b_model k=%0d got=%b exp=%b", k, obs(), exp_v); end
    end
    ncmp++;
    if (bus.md_start !== 1'b1) begin nerr++; $display("FAIL b2b_restart got=%b exp=1", bus.md_start); end
    idle_cycles(MULT_LAT + 1);
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      ncmp++;
      if (obs() !== exp_v) begin nerr++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), exp_v); end
    end
  endtask
  initial begin
    bus.e_valid = 0; bus.e_op = 0; bus.d_uses_hilo = 0; bus.req = 0; bus.div_zero = 0;
    test_reset();
    test_mult_latency();
    test_div_flush();
    test_mthi();
    test_mid_events();
    test_div0();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
